dispatch_stage: RTL and testbench

- Sits between rename and the three reservation stations (ALU, LSU, BRU).
- Holds one renamed uop in a single-entry dispatch register and computes its source-ready bits from an internal physical-register busy table.
- Applies same-cycle writeback bypass to those ready bits, then routes the uop to the reservation station selected by its FU type.
- Sets and clears busy bits, and squashes the held uop on flush or recovery.

---
 rtl/dispatch_stage.sv | 163 ++++++++++++++++
 tb/tb_dispatch_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_stage.sv
// Dispatch stage: single-entry register between rename and the ALU/LSU/BRU
// reservation stations, with a physical-register busy table and writeback bypass.

package ooop_types;
    localparam int PREG_W    = 6;
    localparam int ROB_W     = 4;
    localparam int ROB_DEPTH = 1 << ROB_W;

    typedef struct packed {
        logic              valid;
        logic [ROB_W-1:0]  rob_tag;
        logic [7:0]        opcode;
        logic [PREG_W-1:0] prs1;
        logic              prs1_ready;
        logic [PREG_W-1:0] prs2;
        logic              prs2_ready;
        logic [PREG_W-1:0] prd;
        logic              rd_used;
    } rs_entry_t;

    typedef struct packed {
        logic              valid;
        logic              rd_used;
        logic [PREG_W-1:0] prd;
    } wb_pkt_t;
endpackage

module dispatch_stage #(
    parameter int NUM_PREG  = 1 << ooop_types::PREG_W,
    parameter int ROB_DEPTH = ooop_types::ROB_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    input  logic                          recover_i,
    input  logic [ROB_DEPTH-1:0]          live_tag_i,
    input  logic                          in_valid_i,
    input  ooop_types::rs_entry_t         in_entry_i,
    input  logic [1:0]                    in_fu_i,
    input  logic                          in_rd_used_i,
    input  logic [ooop_types::PREG_W-1:0] in_prd_i,
    output logic                          in_ready_o,
    input  ooop_types::wb_pkt_t           wb_alu_i,
    input  ooop_types::wb_pkt_t           wb_lsu_i,
    input  ooop_types::wb_pkt_t           wb_bru_i,
    input  logic                          alu_rs_ready_i,
    input  logic                          lsu_rs_ready_i,
    input  logic                          bru_rs_ready_i,
    output logic                          alu_insert_valid_o,
    output logic                          lsu_insert_valid_o,
    output logic                          bru_insert_valid_o,
    output ooop_types::rs_entry_t         insert_entry_o
);
    localparam int PREG_W = ooop_types::PREG_W;

    logic                  slot_valid_q;
    ooop_types::rs_entry_t slot_entry_q;
    logic [1:0]            slot_fu_q;
    logic                  slot_rd_used_q;
    logic [PREG_W-1:0]     slot_prd_q;
    logic [NUM_PREG-1:0]   busy_q;
    logic [NUM_PREG-1:0]   busy_next;

    ooop_types::rs_entry_t woken_entry;
    ooop_types::rs_entry_t cap_entry;
    logic is_alu, is_lsu, is_bru, tgt_ready, issue_ok, fire, take;

    function automatic logic wb_hit(input ooop_types::wb_pkt_t a,
                                    input ooop_types::wb_pkt_t l,
                                    input ooop_types::wb_pkt_t b,
                                    input logic [PREG_W-1:0]   p);
        return (p != '0) &&
               ((a.valid && a.rd_used && a.prd == p) ||
                (l.valid && l.rd_used && l.prd == p) ||
                (b.valid && b.rd_used && b.prd == p));
    endfunction

    // Held uop with this cycle's writebacks folded into its ready bits.
    always_comb begin
        woken_entry = slot_entry_q;
        woken_entry.prs1_ready = slot_entry_q.prs1_ready ||
                                 wb_hit(wb_alu_i, wb_lsu_i, wb_bru_i, slot_entry_q.prs1);
        woken_entry.prs2_ready = slot_entry_q.prs2_ready ||
                                 wb_hit(wb_alu_i, wb_lsu_i, wb_bru_i, slot_entry_q.prs2);
    end

    always_comb begin
        cap_entry = in_entry_i;
        cap_entry.valid = 1'b1;
        cap_entry.prs1_ready = (in_entry_i.prs1 == '0) || !busy_q[in_entry_i.prs1] ||
                               wb_hit(wb_alu_i, wb_lsu_i, wb_bru_i, in_entry_i.prs1);
        cap_entry.prs2_ready = (in_entry_i.prs2 == '0) || !busy_q[in_entry_i.prs2] ||
                               wb_hit(wb_alu_i, wb_lsu_i, wb_bru_i, in_entry_i.prs2);
    end

    // FU code 3 is folded onto the ALU so an unexpected encoding still drains.
    always_comb begin
        is_alu = (slot_fu_q == 2'd0) || (slot_fu_q == 2'd3);
        is_lsu = (slot_fu_q == 2'd1);
        is_bru = (slot_fu_q == 2'd2);
        case (slot_fu_q)
            2'd1:    tgt_ready = lsu_rs_ready_i;
            2'd2:    tgt_ready = bru_rs_ready_i;
            default: tgt_ready = alu_rs_ready_i;
        endcase
    end

    assign issue_ok           = slot_valid_q && tgt_ready && !flush_i && !recover_i && !rst;
    assign alu_insert_valid_o = issue_ok && is_alu;
    assign lsu_insert_valid_o = issue_ok && is_lsu;
    assign bru_insert_valid_o = issue_ok && is_bru;
    assign fire               = alu_insert_valid_o || lsu_insert_valid_o || bru_insert_valid_o;
    assign in_ready_o         = (!slot_valid_q || fire) && !flush_i && !recover_i && !rst;
    assign take               = in_valid_i && in_ready_o;

    always_comb begin
        insert_entry_o = '0;
        if (slot_valid_q) begin
            insert_entry_o         = woken_entry;
            insert_entry_o.valid   = 1'b1;
            insert_entry_o.prd     = slot_prd_q;
            insert_entry_o.rd_used = slot_rd_used_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            slot_valid_q <= 1'b0;
        end else if (recover_i) begin
            if (slot_valid_q && !live_tag_i[slot_entry_q.rob_tag])
                slot_valid_q <= 1'b0;
            else
                slot_entry_q <= woken_entry;
        end else if (take) begin
            slot_valid_q   <= 1'b1;
            slot_entry_q   <= cap_entry;
            slot_fu_q      <= in_fu_i;
            slot_rd_used_q <= in_rd_used_i;
            slot_prd_q     <= in_prd_i;
        end else if (fire) begin
            slot_valid_q <= 1'b0;
        end else begin
            slot_entry_q <= woken_entry;
        end
    end

    // Clears first, then the new destination set, so a same-cycle set wins.
    always_comb begin
        busy_next = busy_q;
        if (wb_alu_i.valid && wb_alu_i.rd_used) busy_next[wb_alu_i.prd] = 1'b0;
        if (wb_lsu_i.valid && wb_lsu_i.rd_used) busy_next[wb_lsu_i.prd] = 1'b0;
        if (wb_bru_i.valid && wb_bru_i.rd_used) busy_next[wb_bru_i.prd] = 1'b0;
        if (take && in_rd_used_i && in_prd_i != '0) busy_next[in_prd_i] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i)
            busy_q <= '0;
        else
            busy_q <= busy_next;
    end
endmodule

// File: tb/tb_dispatch_stage.sv
// Directed bench for dispatch_stage: table of per-cycle vectors for the
// pass-through path plus hand-written stall, recovery, flush and reset sequences.

module tb_dispatch_stage;
    import ooop_types::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush_i;
    logic                 recover_i;
    logic [ROB_DEPTH-1:0] live_tag_i;
    logic                 in_valid_i;
    rs_entry_t            in_entry_i;
    logic [1:0]           in_fu_i;
    logic                 in_rd_used_i;
    logic [PREG_W-1:0]    in_prd_i;
    logic                 in_ready_o;
    wb_pkt_t              wb_alu_i, wb_lsu_i, wb_bru_i;
    logic                 alu_rs_ready_i, lsu_rs_ready_i, bru_rs_ready_i;
    logic                 alu_insert_valid_o, lsu_insert_valid_o, bru_insert_valid_o;
    rs_entry_t            insert_entry_o;

    int n_cmp  = 0;
    int n_fail = 0;

    dispatch_stage dut (
        .clk                (clk),
        .rst                (rst),
        .flush_i            (flush_i),
        .recover_i          (recover_i),
        .live_tag_i         (live_tag_i),
        .in_valid_i         (in_valid_i),
        .in_entry_i         (in_entry_i),
        .in_fu_i            (in_fu_i),
        .in_rd_used_i       (in_rd_used_i),
        .in_prd_i           (in_prd_i),
        .in_ready_o         (in_ready_o),
        .wb_alu_i           (wb_alu_i),
        .wb_lsu_i           (wb_lsu_i),
        .wb_bru_i           (wb_bru_i),
        .alu_rs_ready_i     (alu_rs_ready_i),
        .lsu_rs_ready_i     (lsu_rs_ready_i),
        .bru_rs_ready_i     (bru_rs_ready_i),
        .alu_insert_valid_o (alu_insert_valid_o),
        .lsu_insert_valid_o (lsu_insert_valid_o),
        .bru_insert_valid_o (bru_insert_valid_o),
        .insert_entry_o     (insert_entry_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic              in_v;
        logic [1:0]        fu;
        logic [3:0]        tag;
        logic [PREG_W-1:0] p1, p2, pd;
        logic              rdu;
        logic [PREG_W-1:0] wba, wbl, wbb;
        logic              exp_rdy;
        logic [2:0]        exp_ins;
        logic              exp_v, exp_r1, exp_r2;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mkv(input string n, input logic v, input logic [1:0] fu,
                                 input logic [3:0] tag, input logic [5:0] p1,
                                 input logic [5:0] p2, input logic [5:0] pd, input logic rdu,
                                 input logic [5:0] wba, input logic [5:0] wbl,
                                 input logic [5:0] wbb, input logic rdy, input logic [2:0] ins,
                                 input logic ev, input logic r1, input logic r2);
        vec_t t;
        t.name = n; t.in_v = v; t.fu = fu; t.tag = tag; t.p1 = p1; t.p2 = p2; t.pd = pd;
        t.rdu = rdu; t.wba = wba; t.wbl = wbl; t.wbb = wbb; t.exp_rdy = rdy;
        t.exp_ins = ins; t.exp_v = ev; t.exp_r1 = r1; t.exp_r2 = r2;
        return t;
    endfunction

    function automatic wb_pkt_t mk_wb(input logic [PREG_W-1:0] p);
        wb_pkt_t w;
        w = '0;
        if (p != '0) begin
            w.valid = 1'b1; w.rd_used = 1'b1; w.prd = p;
        end
        return w;
    endfunction

    // Incoming ready fields are forced to 1 so any use of them shows up as a wrong ready bit.
    task automatic set_uop(input logic v, input logic [1:0] fu, input logic [3:0] tag,
                           input logic [5:0] p1, input logic [5:0] p2, input logic [5:0] pd,
                           input logic rdu);
        in_valid_i   = v;
        in_fu_i      = fu;
        in_rd_used_i = rdu;
        in_prd_i     = pd;
        in_entry_i   = '0;
        in_entry_i.valid      = v;
        in_entry_i.rob_tag    = tag;
        in_entry_i.opcode     = 8'hA0 | {4'h0, tag};
        in_entry_i.prs1       = p1;
        in_entry_i.prs1_ready = 1'b1;
        in_entry_i.prs2       = p2;
        in_entry_i.prs2_ready = 1'b1;
        in_entry_i.prd        = pd;
        in_entry_i.rd_used    = rdu;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        set_uop(v.in_v, v.fu, v.tag, v.p1, v.p2, v.pd, v.rdu);
        wb_alu_i = mk_wb(v.wba);
        wb_lsu_i = mk_wb(v.wbl);
        wb_bru_i = mk_wb(v.wbb);
        #1;
    endtask

    task automatic check_strobes(input string name, input logic [2:0] exp);
        checkOutput(name, {bru_insert_valid_o, lsu_insert_valid_o, alu_insert_valid_o}, exp);
    endtask

    rs_entry_t exp_e;

    initial begin
        rst = 1'b1; flush_i = 1'b0; recover_i = 1'b0; live_tag_i = '1;
        set_uop(1'b0, 2'd0, 4'd0, 6'd0, 6'd0, 6'd0, 1'b0);
        wb_alu_i = '0; wb_lsu_i = '0; wb_bru_i = '0;
        alu_rs_ready_i = 1'b1; lsu_rs_ready_i = 1'b1; bru_rs_ready_i = 1'b1;

        //             name            v fu tag p1  p2  pd  rdu wba wbl wbb rdy ins     v r1 r2
        vecs[0] = mkv("A_take",       1, 0, 1,  5,  0,  9,  1,  0,  0,  0,  1, 3'b000, 0, 0, 0);
        vecs[1] = mkv("A_ins_B_take", 1, 0, 2,  9,  0,  10, 1,  0,  0,  0,  1, 3'b001, 1, 1, 1);
        vecs[2] = mkv("B_ins_bypass", 0, 0, 0,  0,  0,  0,  0,  9,  0,  0,  1, 3'b001, 1, 1, 1);
        vecs[3] = mkv("C_take_wb20",  1, 0, 3,  9,  10, 20, 1,  0,  0,  20, 1, 3'b000, 0, 0, 0);
        vecs[4] = mkv("C_ins_D_take", 1, 2, 4,  20, 0,  0,  0,  0,  0,  0,  1, 3'b001, 1, 1, 0);
        vecs[5] = mkv("D_ins_E_take", 1, 3, 5,  0,  0,  0,  0,  0,  0,  0,  1, 3'b100, 1, 0, 1);
        vecs[6] = mkv("E_ins_fu3",    0, 0, 0,  0,  0,  0,  0,  0,  0,  0,  1, 3'b001, 1, 1, 1);
        vecs[7] = mkv("empty",        0, 0, 0,  0,  0,  0,  0,  0,  0,  0,  1, 3'b000, 0, 0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checkOutput("rst_in_ready", in_ready_o, 0);
        check_strobes("rst_strobes", 3'b000);
        checkOutput("rst_entry", insert_entry_o, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            checkOutput({vecs[i].name, "_rdy"}, in_ready_o, vecs[i].exp_rdy);
            check_strobes({vecs[i].name, "_ins"}, vecs[i].exp_ins);
            checkOutput({vecs[i].name, "_v"}, insert_entry_o.valid, vecs[i].exp_v);
            checkOutput({vecs[i].name, "_r1"}, insert_entry_o.prs1_ready, vecs[i].exp_r1);
            checkOutput({vecs[i].name, "_r2"}, insert_entry_o.prs2_ready, vecs[i].exp_r2);
        end
        checkOutput("busy9_cleared", dut.busy_q[9], 0);
        checkOutput("busy10_set", dut.busy_q[10], 1);
        checkOutput("busy20_set_wins", dut.busy_q[20], 1);

        // LSU stall: producer of p12 first, then a consumer held four cycles.
        @(negedge clk);
        set_uop(1, 0, 7, 0, 0, 12, 1); #1;
        checkOutput("P_take_rdy", in_ready_o, 1);
        @(negedge clk);
        set_uop(0, 0, 0, 0, 0, 0, 0); #1;
        check_strobes("P_ins", 3'b001);
        @(negedge clk);
        lsu_rs_ready_i = 1'b0;
        set_uop(1, 1, 3, 0, 12, 13, 1); #1;
        checkOutput("L_take_rdy", in_ready_o, 1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            set_uop(0, 0, 0, 0, 0, 0, 0);
            wb_lsu_i = mk_wb((i == 2) ? 6'd12 : 6'd0);
            #1;
            checkOutput($sformatf("stall%0d_rdy", i), in_ready_o, 0);
            check_strobes($sformatf("stall%0d_ins", i), 3'b000);
            checkOutput($sformatf("stall%0d_v", i), insert_entry_o.valid, 1);
            checkOutput($sformatf("stall%0d_r2", i), insert_entry_o.prs2_ready, (i >= 2));
        end
        @(negedge clk);
        wb_lsu_i = '0; lsu_rs_ready_i = 1'b1; #1;
        check_strobes("stall5_ins", 3'b010);
        checkOutput("stall5_rdy", in_ready_o, 1);
        exp_e = '0;
        exp_e.valid = 1; exp_e.rob_tag = 3; exp_e.opcode = 8'hA3;
        exp_e.prs1 = 0; exp_e.prs1_ready = 1; exp_e.prs2 = 12; exp_e.prs2_ready = 1;
        exp_e.prd = 13; exp_e.rd_used = 1;
        checkOutput("stall5_entry", insert_entry_o, exp_e);

        // Recovery that kills the held uop.
        @(negedge clk);
        alu_rs_ready_i = 1'b0;
        set_uop(1, 0, 6, 0, 0, 0, 0); #1;
        checkOutput("R0_rdy", in_ready_o, 1);
        @(negedge clk);
        alu_rs_ready_i = 1'b1; recover_i = 1'b1; live_tag_i = '1; live_tag_i[6] = 1'b0;
        set_uop(1, 0, 8, 0, 0, 0, 0); #1;
        check_strobes("R1_kill_ins", 3'b000);
        checkOutput("R1_kill_rdy", in_ready_o, 0);
        @(negedge clk);
        recover_i = 1'b0; live_tag_i = '1;
        set_uop(0, 0, 0, 0, 0, 0, 0); #1;
        checkOutput("R2_killed_v", insert_entry_o.valid, 0);
        check_strobes("R2_killed_ins", 3'b000);

        // Recovery that keeps the held uop; a wakeup lands during recover.
        @(negedge clk);
        alu_rs_ready_i = 1'b0;
        set_uop(1, 0, 6, 13, 0, 0, 0); #1;
        @(negedge clk);
        alu_rs_ready_i = 1'b1; recover_i = 1'b1;
        set_uop(0, 0, 0, 0, 0, 0, 0);
        wb_alu_i = mk_wb(6'd13); #1;
        check_strobes("K1_keep_ins", 3'b000);
        checkOutput("K1_keep_rdy", in_ready_o, 0);
        checkOutput("K1_keep_r1", insert_entry_o.prs1_ready, 1);
        @(negedge clk);
        recover_i = 1'b0; wb_alu_i = '0; #1;
        check_strobes("K2_ins", 3'b001);
        checkOutput("K2_tag", insert_entry_o.rob_tag, 6);
        checkOutput("K2_r1_held", insert_entry_o.prs1_ready, 1);
        checkOutput("busy13_cleared", dut.busy_q[13], 0);

        // Flush with a full slot and a busy destination.
        @(negedge clk);
        alu_rs_ready_i = 1'b0;
        set_uop(1, 0, 9, 0, 0, 3, 1); #1;
        @(negedge clk);
        alu_rs_ready_i = 1'b1; flush_i = 1'b1;
        set_uop(1, 0, 11, 0, 0, 4, 1); #1;
        checkOutput("F1_busy3", dut.busy_q[3], 1);
        check_strobes("F1_ins", 3'b000);
        checkOutput("F1_rdy", in_ready_o, 0);
        @(negedge clk);
        flush_i = 1'b0;
        set_uop(0, 0, 0, 0, 0, 0, 0); #1;
        checkOutput("F2_entry", insert_entry_o, 0);
        checkOutput("F2_busy_all", dut.busy_q, 0);

        // Reset in the middle of a stall.
        @(negedge clk);
        alu_rs_ready_i = 1'b0;
        set_uop(1, 0, 10, 0, 0, 7, 1); #1;
        @(negedge clk);
        set_uop(0, 0, 0, 0, 0, 0, 0); #1;
        checkOutput("G1_held_v", insert_entry_o.valid, 1);
        checkOutput("G1_rdy", in_ready_o, 0);
        @(negedge clk);
        rst = 1'b1; #1;
        checkOutput("G2_rst_rdy", in_ready_o, 0);
        check_strobes("G2_rst_ins", 3'b000);
        @(negedge clk);
        rst = 1'b0; alu_rs_ready_i = 1'b1; #1;
        checkOutput("G3_entry", insert_entry_o, 0);
        check_strobes("G3_ins", 3'b000);
        checkOutput("G3_rdy", in_ready_o, 1);
        checkOutput("G3_busy_all", dut.busy_q, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
